// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code table and encoder for display blocks
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} codes for decimal digits 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] i_digit);
        logic [6:0] w_code;
        w_code = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (i_digit == 4'(i)) begin
                w_code = SEG_DIGIT[i];
            end
        end
        return w_code;
    endfunction

endpackage

// File: rtl/seg7_count_display_decoder.sv
// rtl/seg7_count_display_decoder.sv - combinational digit to active-high segment code
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_code
);

    assign o_code = seg7_encode(i_digit);

endmodule

// File: rtl/seg7_count_display.sv
// rtl/seg7_count_display.sv - 2-digit multiplexed decimal display of a 0..15 count
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 125000,
    parameter int GHOST_CYC  = 16,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int   CW  = $clog2(SCAN_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CW-1:0] r_scan_cnt;
    logic          r_digit;
    logic [3:0]    r_value_q;

    logic          w_wrap;
    logic          w_ghost;
    logic          w_tens;
    logic [3:0]    w_ones;
    logic [3:0]    w_bcd;
    logic [6:0]    w_code;
    logic          w_blank;
    logic [6:0]    w_seg_ah;
    logic [1:0]    w_an_ah;

    assign w_wrap  = (r_scan_cnt == CW'(SCAN_DIV - 1));
    assign w_ghost = (32'(r_scan_cnt) < GHOST_CYC);

    assign w_tens  = (r_value_q >= 4'd10);
    assign w_ones  = w_tens ? (r_value_q - 4'd10) : r_value_q;
    // Mux the BCD digit first so a single decoder serves both slots
    assign w_bcd   = r_digit ? {3'b000, w_tens} : w_ones;

    seg7_decoder u_decoder (
        .i_digit (w_bcd),
        .o_code  (w_code)
    );

    assign w_blank  = r_digit && !w_tens && (BLANK_LZ != 0);
    assign w_seg_ah = w_blank ? SEG_BLANK : w_code;
    assign w_an_ah  = (en && !w_ghost) ? (r_digit ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 1'b0;
            r_value_q  <= 4'd0;
            frame_tick <= 1'b0;
            seg        <= {7{POL}};
            an         <= {2{POL}};
            dp         <= POL;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
            if (w_wrap) begin
                r_digit <= ~r_digit;
            end
            // Sample only at the frame boundary so a frame never mixes two values
            if (w_wrap && r_digit) begin
                r_value_q <= value;
            end
            frame_tick <= w_wrap && r_digit;
            seg        <= w_seg_ah ^ {7{POL}};
            an         <= w_an_ah ^ {2{POL}};
            dp         <= POL;
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// tb/tb_seg7_count_display.sv - scoreboard bench for seg7_count_display
module tb_seg7_count_display;

    localparam int SCAN  = 8;
    localparam int GHOST = 2;
    localparam int FRAME = 2 * SCAN;

    localparam logic [6:0] DIG [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef struct {
        logic [6:0] seg;
        logic [6:0] seg_nz;
        logic [1:0] an;
        logic       dp;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] value;

    logic [6:0] seg, seg_nz;
    logic [1:0] an, an_nz;
    logic       dp, dp_nz;
    logic       frame_tick, frame_tick_nz;

    exp_t sb[$];
    int   k       = 0;
    int   vq      = 0;
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seg7_count_display #(
        .SCAN_DIV(SCAN), .GHOST_CYC(GHOST), .BLANK_LZ(1), .ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .value(value),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    seg7_count_display #(
        .SCAN_DIV(SCAN), .GHOST_CYC(GHOST), .BLANK_LZ(0), .ACTIVE_LOW(1)
    ) u_dut_nz (
        .clk(clk), .rst(rst), .en(en), .value(value),
        .seg(seg_nz), .dp(dp_nz), .an(an_nz), .frame_tick(frame_tick_nz)
    );

    // Active-high code a human reading the display expects for a slot
    function automatic logic [6:0] ref_code(input int v, input int slot, input bit blz);
        int tens, ones;
        tens = v / 10;
        ones = v % 10;
        if (slot == 0) return DIG[ones];
        if (tens == 0) return blz ? 7'h00 : DIG[0];
        return DIG[tens];
    endfunction

    // Reference model: position in the frame comes from cycles elapsed since reset
    always @(posedge clk) begin
        exp_t e;
        int   pos, slot;
        if (rst) begin
            e.seg = 7'h7F; e.seg_nz = 7'h7F; e.an = 2'b11; e.dp = 1'b1; e.tick = 1'b0;
            k = 0;
            vq = 0;
            started = 1'b1;
            sb.push_back(e);
        end else if (started) begin
            pos  = k % SCAN;
            slot = (k / SCAN) % 2;
            e.seg    = ~ref_code(vq, slot, 1'b1);
            e.seg_nz = ~ref_code(vq, slot, 1'b0);
            e.an     = (en && pos >= GHOST) ? ((slot == 1) ? 2'b01 : 2'b10) : 2'b11;
            e.dp     = 1'b1;
            e.tick   = ((k % FRAME) == FRAME - 1);
            if (e.tick) vq = int'(value);
            k++;
            sb.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("seg",     {1'b0, seg},     {1'b0, e.seg});
            chk("seg_nz",  {1'b0, seg_nz},  {1'b0, e.seg_nz});
            chk("an",      {6'd0, an},      {6'd0, e.an});
            chk("an_nz",   {6'd0, an_nz},   {6'd0, e.an});
            chk("dp",      {7'd0, dp},      {7'd0, e.dp});
            chk("dp_nz",   {7'd0, dp_nz},   {7'd0, e.dp});
            chk("tick",    {7'd0, frame_tick},    {7'd0, e.tick});
            chk("tick_nz", {7'd0, frame_tick_nz}, {7'd0, e.tick});
        end
    end

    task automatic wait_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            if ((k % FRAME) == p) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_pos timeout: got no position %0d, expected it within %0d cycles", p, 2 * FRAME);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; value = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        value = 4'd7;  repeat (40) @(negedge clk);
        value = 4'd13; repeat (36) @(negedge clk);
        value = 4'd15; repeat (36) @(negedge clk);

        value = 4'd4;  repeat (32) @(negedge clk);
        wait_pos(3);
        value = 4'd9;  repeat (36) @(negedge clk);

        en = 1'b0; repeat (20) @(negedge clk);
        en = 1'b1; repeat (20) @(negedge clk);
        en = 1'b0; wait_pos(SCAN);
        en = 1'b1; repeat (12) @(negedge clk);

        value = 4'd12; repeat (40) @(negedge clk);
        wait_pos(5);
        rst = 1'b1; @(negedge clk);
        rst = 1'b0; value = 4'd3;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) value = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; en = 1'b1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
